// File: rtl/axi_pkg.sv
// Shared AXI3 channel widths, payload types and fixed IDs for the read-path
// arbitration logic.
package axi_pkg;

  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;
  localparam int AXI_LOCK_W  = 2;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;
  localparam int AXI_ID_W    = 4;

  typedef logic [AXI_ADDR_W-1:0]  addr_t;
  typedef logic [AXI_DATA_W-1:0]  data_t;
  typedef logic [AXI_LEN_W-1:0]   len_t;
  typedef logic [AXI_SIZE_W-1:0]  size_t;
  typedef logic [AXI_BURST_W-1:0] burst_t;
  typedef logic [AXI_RESP_W-1:0]  resp_t;
  typedef logic [AXI_ID_W-1:0]    id_t;

  localparam burst_t AXI_BURST_FIXED = 2'b00;
  localparam burst_t AXI_BURST_INCR  = 2'b01;
  localparam burst_t AXI_BURST_WRAP  = 2'b10;
  localparam resp_t  AXI_RESP_OKAY   = 2'b00;

  // Upstream master slots as seen on m_arid by the top-level port.
  localparam id_t AXI_ID_ICACHE   = 4'd0;
  localparam id_t AXI_ID_DCACHE   = 4'd1;
  localparam id_t AXI_ID_UNCACHED = 4'd2;

  typedef struct packed {
    addr_t  addr;
    len_t   len;
    size_t  size;
    burst_t burst;
  } ar_req_t;

  typedef enum logic {
    AR_EMPTY = 1'b0,
    AR_FULL  = 1'b1
  } ar_stage_e;

  function automatic int unsigned cnt_width(input int unsigned max_outs);
    return $clog2(max_outs + 1);
  endfunction

endpackage

// File: rtl/axi_read_rr_arbit_rr_arbiter.sv
// Combinational round-robin picker: search starts one past ptr and wraps,
// first requester found wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = IW'((32'(ptr) + k) % N);
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_rr_arbit.sv
// N-master AXI3 read arbiter: round-robin AR grant into a one-entry output
// register, per-master outstanding-burst limits, R demux by ID.
module axi_read_rr_arbit
  import axi_pkg::*;
#(
  parameter int NUM_M    = 2,
  parameter int ID_W     = 4,
  parameter int MAX_OUTS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_M*AXI_ADDR_W-1:0]   s_araddr,
  input  logic [NUM_M*AXI_LEN_W-1:0]    s_arlen,
  input  logic [NUM_M*AXI_SIZE_W-1:0]   s_arsize,
  input  logic [NUM_M*AXI_BURST_W-1:0]  s_arburst,
  input  logic [NUM_M-1:0]              s_arvalid,
  output logic [NUM_M-1:0]              s_arready,
  output logic [NUM_M*AXI_DATA_W-1:0]   s_rdata,
  output logic [NUM_M*AXI_RESP_W-1:0]   s_rresp,
  output logic [NUM_M-1:0]              s_rlast,
  output logic [NUM_M-1:0]              s_rvalid,
  input  logic [NUM_M-1:0]              s_rready,
  output logic [ID_W-1:0]               m_arid,
  output logic [AXI_ADDR_W-1:0]         m_araddr,
  output logic [AXI_LEN_W-1:0]          m_arlen,
  output logic [AXI_SIZE_W-1:0]         m_arsize,
  output logic [AXI_BURST_W-1:0]        m_arburst,
  output logic [AXI_LOCK_W-1:0]         m_arlock,
  output logic [AXI_CACHE_W-1:0]        m_arcache,
  output logic [AXI_PROT_W-1:0]         m_arprot,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [ID_W-1:0]               m_rid,
  input  logic [AXI_DATA_W-1:0]         m_rdata,
  input  logic [AXI_RESP_W-1:0]         m_rresp,
  input  logic                          m_rlast,
  input  logic                          m_rvalid,
  output logic                          m_rready
);

  localparam int IW = $clog2(NUM_M);
  localparam int CW = cnt_width(MAX_OUTS);

  ar_stage_e       state_q, state_d;
  ar_req_t         ar_q, req_sel;
  logic [ID_W-1:0] arid_q;
  logic [IW-1:0]   ptr, gidx;
  logic [NUM_M-1:0] elig, grant, inc, dec;
  logic            any_grant, free, accept, rid_ok, bad_rid;
  logic [CW-1:0]   outs [NUM_M];

  rr_arbiter #(
    .N  (NUM_M),
    .IW (IW)
  ) u_rr (
    .req   (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any_grant)
  );

  // A full stage can still take a new request in the cycle it is drained.
  assign free      = (state_q == AR_EMPTY) || m_arready;
  assign accept    = any_grant && free && !rst;
  assign s_arready = accept ? grant : '0;
  assign inc       = accept ? grant : '0;

  always_comb begin
    req_sel = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (grant[i]) begin
        req_sel.addr  = s_araddr[i*AXI_ADDR_W +: AXI_ADDR_W];
        req_sel.len   = s_arlen[i*AXI_LEN_W +: AXI_LEN_W];
        req_sel.size  = s_arsize[i*AXI_SIZE_W +: AXI_SIZE_W];
        req_sel.burst = s_arburst[i*AXI_BURST_W +: AXI_BURST_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= AR_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      AR_EMPTY: if (accept) state_d = AR_FULL;
      AR_FULL:  if (m_arready && !accept) state_d = AR_EMPTY;
      default:  state_d = AR_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q   <= '0;
      arid_q <= '0;
      ptr    <= IW'(NUM_M - 1);
    end else if (accept) begin
      ar_q   <= req_sel;
      arid_q <= ID_W'(gidx);
      ptr    <= gidx;
    end
  end

  assign m_arvalid = (state_q == AR_FULL);
  assign m_arid    = arid_q;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = ar_q.burst;
  assign m_arlock  = '0;
  assign m_arcache = '0;
  assign m_arprot  = '0;

  assign s_rdata = {NUM_M{m_rdata}};
  assign s_rresp = {NUM_M{m_rresp}};
  assign s_rlast = {NUM_M{m_rlast}};
  assign rid_ok  = (m_rid < ID_W'(NUM_M));

  // Unknown IDs default to m_rready=1 so a stray beat can never wedge the bus.
  always_comb begin
    s_rvalid = '0;
    m_rready = 1'b1;
    dec      = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (m_rid == ID_W'(i)) begin
        s_rvalid[i] = m_rvalid;
        m_rready    = s_rready[i];
        dec[i]      = m_rvalid && s_rready[i] && m_rlast;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     bad_rid <= 1'b0;
    else if (m_rvalid && !rid_ok) bad_rid <= 1'b1;
  end

  for (genvar i = 0; i < NUM_M; i++) begin : g_outs
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst)                                cnt <= '0;
      else if (inc[i] && !dec[i])             cnt <= cnt + 1'b1;
      else if (dec[i] && !inc[i] && cnt != '0) cnt <= cnt - 1'b1;
    end

    assign outs[i] = cnt;
    assign elig[i] = s_arvalid[i] && (cnt < CW'(MAX_OUTS));

    a_no_dec_at_zero: assert property (@(posedge clk) disable iff (rst)
      !(dec[i] && !inc[i] && cnt == '0));
  end

  a_bad_rid_sticky: assert property (@(posedge clk) disable iff (rst)
    bad_rid |=> bad_rid);

  a_ar_stable: assert property (@(posedge clk) disable iff (rst)
    (m_arvalid && !m_arready) |=> (m_arvalid && $stable(m_araddr) && $stable(m_arid)));

endmodule

// File: tb/tb_axi_read_rr_arbit.sv
// Scoreboard bench for axi_read_rr_arbit with three masters and a two-burst
// outstanding limit.
module tb_axi_read_rr_arbit;

  localparam int NM  = 3;
  localparam int IDW = 4;
  localparam int MO  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM*32-1:0] s_araddr;
  logic [NM*4-1:0]  s_arlen;
  logic [NM*3-1:0]  s_arsize;
  logic [NM*2-1:0]  s_arburst;
  logic [NM-1:0]    s_arvalid, s_arready;
  logic [NM*32-1:0] s_rdata;
  logic [NM*2-1:0]  s_rresp;
  logic [NM-1:0]    s_rlast, s_rvalid, s_rready;
  logic [IDW-1:0]   m_arid;
  logic [31:0]      m_araddr;
  logic [3:0]       m_arlen;
  logic [2:0]       m_arsize;
  logic [1:0]       m_arburst, m_arlock;
  logic [3:0]       m_arcache;
  logic [2:0]       m_arprot;
  logic             m_arvalid, m_arready;
  logic [IDW-1:0]   m_rid;
  logic [31:0]      m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rlast, m_rvalid, m_rready;

  axi_read_rr_arbit #(.NUM_M(NM), .ID_W(IDW), .MAX_OUTS(MO)) dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_exp_t;

  ar_exp_t exp_q[$];

  task automatic push_ar(input int id, input logic [31:0] a, input logic [3:0] l);
    ar_exp_t e;
    e.id   = 4'(id);
    e.addr = a;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  // AR handshakes are taken at the next rising edge; sample mid-cycle.
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr = '0;
  ar_exp_t     mon_e;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("ar_hold_valid", 64'(m_arvalid), 64'd1);
        check("ar_hold_addr", 64'(m_araddr), 64'(stall_addr));
      end
      if (m_arvalid && m_arready) begin
        check("ar_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("ar_id", 64'(m_arid), 64'(mon_e.id));
          check("ar_addr", 64'(m_araddr), 64'(mon_e.addr));
          check("ar_len", 64'(m_arlen), 64'(mon_e.len));
        end
      end
      stall_prev <= m_arvalid && !m_arready;
      stall_addr <= m_araddr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_araddr  = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arvalid = '0; s_rready = '0; m_arready = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int m, input logic [31:0] a, input logic [3:0] l);
    s_araddr[m*32 +: 32] = a;
    s_arlen[m*4 +: 4]    = l;
    s_arsize[m*3 +: 3]   = 3'd2;
    s_arburst[m*2 +: 2]  = 2'b01;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // reset values, including s_arready held low under rst with requests present
    rst = 1'b1;
    idle_inputs();
    s_arvalid = '1;
    m_arready = 1'b1;
    tick();
    tick();
    check("rst_arready", 64'(s_arready), 64'd0);
    check("rst_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_arid", 64'(m_arid), 64'd0);
    check("rst_araddr", 64'(m_araddr), 64'd0);
    check("rst_ptr", 64'(dut.ptr), 64'(NM - 1));
    check("rst_outs0", 64'(dut.outs[0]), 64'd0);
    check("rst_bad_rid", 64'(dut.bad_rid), 64'd0);
    check("rst_rvalid", 64'(s_rvalid), 64'd0);
    check("const_lcp", 64'({m_arlock, m_arcache, m_arprot}), 64'd0);
    do_reset();

    // single master burst, R beats routed only to master 0
    set_req(0, 32'h1FC0_0000, 4'd3);
    s_arvalid = 3'b001;
    m_arready = 1'b1;
    push_ar(0, 32'h1FC0_0000, 4'd3);
    #1 check("t1_arready", 64'(s_arready), 64'b001);
    tick();
    s_arvalid = '0;
    #1;
    check("t1_arvalid", 64'(m_arvalid), 64'd1);
    check("t1_arid", 64'(m_arid), 64'd0);
    check("t1_arsize", 64'(m_arsize), 64'd2);
    check("t1_outs_inc", 64'(dut.outs[0]), 64'd1);
    tick();
    check("t1_ar_empty", 64'(m_arvalid), 64'd0);
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1;
      m_rid    = '0;
      m_rdata  = 32'hD000_0000 + 32'(b);
      m_rlast  = (b == 3);
      s_rready = 3'b001;
      #1;
      check("t1_rvalid", 64'(s_rvalid), 64'b001);
      check("t1_rdata0", 64'(s_rdata[31:0]), 64'(32'hD000_0000 + 32'(b)));
      check("t1_rdata2", 64'(s_rdata[95:64]), 64'(32'hD000_0000 + 32'(b)));
      check("t1_rready", 64'(m_rready), 64'd1);
      check("t1_outs_mid", 64'(dut.outs[0]), 64'd1);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    check("t1_outs_done", 64'(dut.outs[0]), 64'd0);
    check("t1_rvalid_idle", 64'(s_rvalid), 64'd0);
    drain("t1_drain");
    do_reset();

    // three-way contention: 0,1,2,0,1,2 then all masters hit MAX_OUTS
    for (int m = 0; m < NM; m++) set_req(m, 32'hA000_0000 + 32'(m * 'h100), 4'(m));
    s_arvalid = 3'b111;
    m_arready = 1'b1;
    for (int k = 0; k < 6; k++) push_ar(k % 3, 32'hA000_0000 + 32'((k % 3) * 'h100), 4'(k % 3));
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t2_grant", 64'(s_arready), 64'(1) << (k % 3));
      if (k > 0) check("t2_arid", 64'(m_arid), 64'((k - 1) % 3));
      tick();
    end
    #1;
    check("t2_saturated", 64'(s_arready), 64'd0);
    check("t2_arid_last", 64'(m_arid), 64'd2);
    check("t2_outs2", 64'(dut.outs[2]), 64'd2);
    s_arvalid = '0;
    drain("t2_drain");
    do_reset();

    // backpressure with m1 held, then back-to-back load of m0
    m_arready = 1'b0;
    set_req(1, 32'hB100_0000, 4'd1);
    s_arvalid = 3'b010;
    push_ar(1, 32'hB100_0000, 4'd1);
    #1 check("t3_first", 64'(s_arready), 64'b010);
    tick();
    set_req(0, 32'hB000_0000, 4'd2);
    s_arvalid = 3'b001;
    push_ar(0, 32'hB000_0000, 4'd2);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t3_hold_valid", 64'(m_arvalid), 64'd1);
      check("t3_hold_addr", 64'(m_araddr), 64'hB100_0000);
      check("t3_no_ready", 64'(s_arready), 64'd0);
      tick();
    end
    m_arready = 1'b1;
    #1 check("t3_b2b_ready", 64'(s_arready), 64'b001);
    tick();
    s_arvalid = '0;
    #1;
    check("t3_b2b_valid", 64'(m_arvalid), 64'd1);
    check("t3_b2b_addr", 64'(m_araddr), 64'hB000_0000);
    check("t3_b2b_id", 64'(m_arid), 64'd0);
    tick();
    check("t3_empty", 64'(m_arvalid), 64'd0);
    drain("t3_drain");
    do_reset();

    // outstanding limit on master 0
    m_arready = 1'b1;
    set_req(0, 32'hC000_0000, 4'd0);
    s_arvalid = 3'b001;
    push_ar(0, 32'hC000_0000, 4'd0);
    #1 check("t4_acc1", 64'(s_arready), 64'b001);
    tick();
    push_ar(0, 32'hC000_0000, 4'd0);
    #1 check("t4_acc2", 64'(s_arready), 64'b001);
    tick();
    set_req(1, 32'hC100_0000, 4'd0);
    s_arvalid = 3'b011;
    push_ar(1, 32'hC100_0000, 4'd0);
    #1;
    check("t4_m1_granted", 64'(s_arready), 64'b010);
    check("t4_outs_full", 64'(dut.outs[0]), 64'(MO));
    tick();
    s_arvalid = 3'b001;
    #1 check("t4_stall", 64'(s_arready), 64'd0);
    tick();
    check("t4_stall2", 64'(s_arready), 64'd0);
    m_rvalid = 1'b1;
    m_rid    = '0;
    m_rlast  = 1'b1;
    s_rready = 3'b001;
    #1 check("t4_stall_rlast", 64'(s_arready), 64'd0);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    push_ar(0, 32'hC000_0000, 4'd0);
    #1;
    check("t4_resume", 64'(s_arready), 64'b001);
    check("t4_outs_dec", 64'(dut.outs[0]), 64'd1);
    tick();
    s_arvalid = '0;
    #1 check("t4_outs_refill", 64'(dut.outs[0]), 64'd2);
    drain("t4_drain");
    do_reset();

    // simultaneous increment and decrement on master 0
    m_arready = 1'b1;
    set_req(0, 32'hE000_0000, 4'd0);
    s_arvalid = 3'b001;
    push_ar(0, 32'hE000_0000, 4'd0);
    #1 check("t5_acc1", 64'(s_arready), 64'b001);
    tick();
    #1 check("t5_outs1", 64'(dut.outs[0]), 64'd1);
    push_ar(0, 32'hE000_0000, 4'd0);
    m_rvalid = 1'b1;
    m_rid    = '0;
    m_rlast  = 1'b1;
    s_rready = 3'b001;
    #1;
    check("t5_acc2", 64'(s_arready), 64'b001);
    check("t5_rready", 64'(m_rready), 64'd1);
    tick();
    s_arvalid = '0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    #1 check("t5_outs_same", 64'(dut.outs[0]), 64'd1);
    drain("t5_drain");

    // out-of-range R id
    m_rvalid = 1'b1;
    m_rid    = 4'd7;
    m_rlast  = 1'b1;
    s_rready = '0;
    #1;
    check("t6_bad_rready", 64'(m_rready), 64'd1);
    check("t6_bad_rvalid", 64'(s_rvalid), 64'd0);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    check("t6_bad_rid", 64'(dut.bad_rid), 64'd1);
    check("t6_outs0_kept", 64'(dut.outs[0]), 64'd1);

    // reset in the middle of a burst with the AR stage full
    m_arready = 1'b0;
    set_req(1, 32'hF100_0000, 4'd3);
    s_arvalid = 3'b010;
    tick();
    m_rvalid = 1'b1;
    m_rid    = 4'd1;
    s_rready = 3'b010;
    #1;
    check("t6_full", 64'(m_arvalid), 64'd1);
    check("t6_outs1", 64'(dut.outs[1]), 64'd1);
    check("t6_mid_rvalid", 64'(s_rvalid), 64'b010);
    rst = 1'b1;
    #1 check("t6_rst_arready", 64'(s_arready), 64'd0);
    tick();
    m_rvalid = 1'b0;
    #1;
    check("t6_rst_arvalid", 64'(m_arvalid), 64'd0);
    check("t6_rst_araddr", 64'(m_araddr), 64'd0);
    check("t6_rst_arid", 64'(m_arid), 64'd0);
    check("t6_rst_outs0", 64'(dut.outs[0]), 64'd0);
    check("t6_rst_outs1", 64'(dut.outs[1]), 64'd0);
    check("t6_rst_bad_rid", 64'(dut.bad_rid), 64'd0);
    check("t6_rst_ptr", 64'(dut.ptr), 64'(NM - 1));
    check("t6_rst_rvalid", 64'(s_rvalid), 64'd0);
    rst = 1'b0;
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
